// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code byte stream to key events, with E0/F0 prefix folding and modifier tracking.
// Optional typematic repeat filter: define PS2_REPEAT_FILTER_EN.
module ps2_scancode_decoder (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  output logic       kbd_nextdata_n,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  output logic [7:0] key_ascii,
  output logic       shift_on,
  output logic       ctrl_on,
  output logic       caps_on
);

  typedef enum logic [1:0] {IDLE, POP, DECODE, EMIT} state_t;

  state_t     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic [7:0] code_q, code_d, ascii_q, ascii_d;
  logic       kext_q, kext_d, krel_q, krel_d;
  logic       lshift_q, lshift_d, rshift_q, rshift_d;
  logic       ctrl_q, ctrl_d, caps_q, caps_d;
  logic       drop;
`ifdef PS2_REPEAT_FILTER_EN
  logic       last_vld_q, last_vld_d;
  logic [8:0] last_make_q, last_make_d;
`endif

  function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic ext,
                                          input logic shift, input logic caps);
    logic [7:0] a;
    a = 8'h00;
    if (!ext) begin
      case (code)
        8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
        8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
        8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
        8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
        8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
        8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
        8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
        8'h16: a = shift ? 8'h21 : 8'h31; 8'h1E: a = shift ? 8'h40 : 8'h32;
        8'h26: a = shift ? 8'h23 : 8'h33; 8'h25: a = shift ? 8'h24 : 8'h34;
        8'h2E: a = shift ? 8'h25 : 8'h35; 8'h36: a = shift ? 8'h5E : 8'h36;
        8'h3D: a = shift ? 8'h26 : 8'h37; 8'h3E: a = shift ? 8'h2A : 8'h38;
        8'h46: a = shift ? 8'h28 : 8'h39; 8'h45: a = shift ? 8'h29 : 8'h30;
        8'h4E: a = shift ? 8'h5F : 8'h2D; 8'h55: a = shift ? 8'h2B : 8'h3D;
        8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
        8'h0D: a = 8'h09; 8'h76: a = 8'h1B;
        default: a = 8'h00;
      endcase
      // Only letters land in 'a'..'z', so case folding can be applied afterwards.
      if (a >= 8'h61 && a <= 8'h7A && (shift ^ caps)) a = a - 8'h20;
    end
    return a;
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    code_d   = code_q;
    ascii_d  = ascii_q;
    kext_d   = kext_q;
    krel_d   = krel_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    ctrl_d   = ctrl_q;
    caps_d   = caps_q;
    drop     = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
    last_vld_d  = last_vld_q;
    last_make_d = last_make_q;
`endif
    case (state_q)
      IDLE: if (kbd_ready) begin
        byte_d  = kbd_data;
        state_d = POP;
      end
      POP: state_d = DECODE;
      DECODE: begin
        state_d = IDLE;
        case (byte_q)
          8'hE0: ext_d = 1'b1;
          8'hF0: brk_d = 1'b1;
          8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
          default: begin
`ifdef PS2_REPEAT_FILTER_EN
            drop = !brk_q && last_vld_q && (last_make_q == {ext_q, byte_q});
`endif
            if (drop) begin
              ext_d = 1'b0;
              brk_d = 1'b0;
            end else begin
              state_d = EMIT;
              code_d  = byte_q;
              kext_d  = ext_q;
              krel_d  = brk_q;
              ascii_d = to_ascii(byte_q, ext_q, lshift_q | rshift_q, caps_q);
              case (byte_q)
                8'h12:   lshift_d = !brk_q;
                8'h59:   rshift_d = !brk_q;
                8'h14:   ctrl_d   = !brk_q;
                8'h58:   if (!brk_q) caps_d = !caps_q;
                default: ;
              endcase
`ifdef PS2_REPEAT_FILTER_EN
              if (!brk_q) begin
                last_vld_d  = 1'b1;
                last_make_d = {ext_q, byte_q};
              end else if (last_make_q == {ext_q, byte_q}) begin
                last_vld_d  = 1'b0;
              end
`endif
            end
          end
        endcase
      end
      EMIT: if (key_ready) begin
        ext_d   = 1'b0;
        brk_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= IDLE;
      byte_q   <= 8'h00;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      code_q   <= 8'h00;
      ascii_q  <= 8'h00;
      kext_q   <= 1'b0;
      krel_q   <= 1'b0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      ctrl_q   <= 1'b0;
      caps_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      code_q   <= code_d;
      ascii_q  <= ascii_d;
      kext_q   <= kext_d;
      krel_q   <= krel_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      ctrl_q   <= ctrl_d;
      caps_q   <= caps_d;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      last_vld_q  <= 1'b0;
      last_make_q <= 9'h000;
    end else begin
      last_vld_q  <= last_vld_d;
      last_make_q <= last_make_d;
    end
  end
`endif

  assign kbd_nextdata_n = (state_q != POP);
  assign key_valid      = (state_q == EMIT);
  assign key_code       = code_q;
  assign key_extended   = kext_q;
  assign key_release    = krel_q;
  assign key_ascii      = ascii_q;
  assign shift_on       = lshift_q | rshift_q;
  assign ctrl_on        = ctrl_q;
  assign caps_on        = caps_q;

endmodule
